// File: rtl/write_back_unit.sv
// Write-back queue feeding the register file write port, with pending scoreboard and forwarding.
// Latency: a result pushed at edge N is presented on en/r during cycle N+1 (empty queue, hold low).
// Backpressure: res_ready drops while the queue holds DEPTH entries; hold stalls retirement only.
module write_back_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid,
  input  logic [15:0]      res_data,
  input  logic [3:0]       res_dest,
  output logic             res_ready,
  input  logic             hold,
  output logic [15:0]      r,
  output logic [15:0]      en,
  output logic [15:0]      pending,
  input  logic [3:0]       fwd_sel,
  output logic             fwd_hit,
  output logic [15:0]      fwd_data,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  // Entry storage; validity comes from the pointers and count, so no reset is needed here.
  logic [15:0]      data_q [DEPTH];
  logic [3:0]       dest_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  // Low during reset and until the first edge after release, so res_ready stays low in reset.
  logic             alive_q, alive_d;

  logic             push;
  logic             pop;
  logic [PTR_W-1:0] idx;

  assign res_ready = alive_q && (count_q < FULL_CNT);
  assign count     = count_q;
  assign push      = res_valid && res_ready;
  assign pop       = |en;

  // Retire the head unless the register file asked us to hold off.
  always_comb begin
    en = '0;
    r  = '0;
    if ((count_q != '0) && !hold) begin
      en = 16'b1 << dest_q[rd_ptr_q];
      r  = data_q[rd_ptr_q];
    end
  end

  // Walk oldest to youngest so the last match left in fwd_data is the youngest one.
  always_comb begin
    pending  = '0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((PTR_W+1)'(k) < count_q) begin
        pending[dest_q[idx]] = 1'b1;
        if (dest_q[idx] == fwd_sel) begin
          fwd_data = data_q[idx];
        end
      end
    end
    fwd_hit = pending[fwd_sel];
  end

  // Pointer and occupancy bookkeeping for push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    alive_d  = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards every queued result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      alive_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      alive_q  <= alive_d;
    end
  end

  // Capture an accepted result at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= res_data;
      dest_q[wr_ptr_q] <= res_dest;
    end
  end

endmodule
